// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory responder
//
// Purpose: state encoding, bus widths and command constants used by the
// responder, its interface and the word storage.
// Ports: none (package).
// Optional feature macro referenced by users of this package: MEM_RESP_ERR_EN.

package mem_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = XLEN / 8;

    // Value of req_wen for each command
    localparam logic MEM_LOAD  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between core and memory responder
//
// Purpose: groups the request and response handshake signals.
// Modports:
//   master - core side: drives req_*, resp_ready; observes req_ready, resp_*
//   slave  - responder side: the mirror image
// Optional feature macro: MEM_RESP_ERR_EN adds resp_err.

interface mem_responder_if;
    import mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
`ifdef MEM_RESP_ERR_EN
    logic              resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`else
    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
`endif

endinterface

// File: rtl/mem_responder_mem_array.sv
// rtl/mem_responder_mem_array.sv - word storage with byte-enabled write and registered read
//
// Purpose: DEPTH_WORDS x 32-bit storage, not reset.
// Ports:
//   i_clk    clock
//   i_we     write enable (byte lanes selected by i_wstrb)
//   i_re     read enable; o_rdata updates at the same edge
//   i_idx    word index
//   i_wdata  write data
//   i_wstrb  byte enables, bit i covers [8i+7:8i]
//   o_rdata  registered read data, holds until the next read

module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    output logic [XLEN-1:0]   o_rdata
);

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];
    logic [XLEN-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder with wait states
//
// Purpose: accepts one request at a time, waits WAIT_CYCLES, performs the
// word access in mem_array, then holds the response until accepted.
// Ports:
//   clk  clock, rising edge
//   rst  asynchronous active-high reset
//   bus  mem_responder_if.slave (req_* in, req_ready/resp_* out)
// Optional feature macro: MEM_RESP_ERR_EN - misaligned / out-of-range
// accesses are flagged on resp_err, suppress the write and return zero data.

module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    mem_state_e        r_state;
    logic [3:0]        r_cnt;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_rdata_en;
    logic              r_err;
    logic              r_wen;
    logic [IDX_W-1:0]  r_idx;
    logic [XLEN-1:0]   r_wdata;
    logic [STRB_W-1:0] r_wstrb;

    logic [IDX_W-1:0]  w_idx;
    logic              w_err_in;
    logic              w_we;
    logic              w_re;
    logic [XLEN-1:0]   w_mem_rdata;

    // Truncation to IDX_W bits gives the modulo-depth wrap
    assign w_idx = IDX_W'((bus.req_addr - BASE_ADDR) >> 2);

`ifdef MEM_RESP_ERR_EN
    logic [XLEN-1:0] w_off;
    assign w_off    = bus.req_addr - BASE_ADDR;
    assign w_err_in = (bus.req_addr[1:0] != 2'b00) || (w_off >= XLEN'(4 * DEPTH_WORDS));
`else
    assign w_err_in = 1'b0;
`endif

    // Access happens only in ACCESS, so a reset during WAIT drops the store
    assign w_we = (r_state == ST_ACCESS) && (r_wen == MEM_WRITE) && !r_err;
    assign w_re = (r_state == ST_ACCESS) && (r_wen == MEM_LOAD)  && !r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata_en   <= 1'b0;
            r_err        <= 1'b0;
            r_wen        <= MEM_LOAD;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_wen       <= bus.req_wen;
                        r_idx       <= w_idx;
                        r_wdata     <= bus.req_wdata;
                        r_wstrb     <= bus.req_wstrb;
                        r_err       <= w_err_in;
                        r_req_ready <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= WAIT_INIT;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                    // Array read data is exposed only for successful loads
                    r_rdata_en   <= (r_wen == MEM_LOAD) && !r_err;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_rdata_en   <= 1'b0;
                        r_err        <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem_array (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .o_rdata (w_mem_rdata)
    );

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata_en ? w_mem_rdata : '0;
`ifdef MEM_RESP_ERR_EN
    assign bus.resp_err   = r_err;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (two configurations)

module tb_mem_responder;

    logic clk;
    logic rst;

    // Index 0: WAIT_CYCLES=1, BASE 0x0; index 1: WAIT_CYCLES=4, BASE 0x100; both 16 words
    logic        rq_valid [2];
    logic        rq_wen   [2];
    logic [31:0] rq_addr  [2];
    logic [31:0] rq_wdata [2];
    logic [3:0]  rq_wstrb [2];
    logic        rs_ready [2];
    logic        rq_ready_o [2];
    logic        rs_valid_o [2];
    logic [31:0] rs_rdata_o [2];
    logic        rs_err_o   [2];

    int          wait_c [2] = '{1, 4};
    logic [31:0] base   [2] = '{32'h0, 32'h100};
    logic [31:0] mdl    [2][16];

    int tests = 0;
    int fails = 0;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave));
    mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(4), .BASE_ADDR(32'h100)) u_dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave));

    assign bus_a.req_valid  = rq_valid[0];
    assign bus_a.req_wen    = rq_wen[0];
    assign bus_a.req_addr   = rq_addr[0];
    assign bus_a.req_wdata  = rq_wdata[0];
    assign bus_a.req_wstrb  = rq_wstrb[0];
    assign bus_a.resp_ready = rs_ready[0];
    assign bus_b.req_valid  = rq_valid[1];
    assign bus_b.req_wen    = rq_wen[1];
    assign bus_b.req_addr   = rq_addr[1];
    assign bus_b.req_wdata  = rq_wdata[1];
    assign bus_b.req_wstrb  = rq_wstrb[1];
    assign bus_b.resp_ready = rs_ready[1];

    assign rq_ready_o[0] = bus_a.req_ready;
    assign rs_valid_o[0] = bus_a.resp_valid;
    assign rs_rdata_o[0] = bus_a.resp_rdata;
    assign rq_ready_o[1] = bus_b.req_ready;
    assign rs_valid_o[1] = bus_b.resp_valid;
    assign rs_rdata_o[1] = bus_b.resp_rdata;
`ifdef MEM_RESP_ERR_EN
    assign rs_err_o[0] = bus_a.resp_err;
    assign rs_err_o[1] = bus_b.resp_err;
`else
    assign rs_err_o[0] = 1'b0;
    assign rs_err_o[1] = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference model: memory as a plain word array; rules straight from the address map
    function automatic logic model_err(input int d, input logic [31:0] a);
`ifdef MEM_RESP_ERR_EN
        return (a % 4 != 0) || ((a - base[d]) >= 32'd64);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_apply(input int d, input logic wen, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [3:0] s,
                                        output logic [31:0] erd, output logic eerr);
        int idx;
        idx  = int'(((a - base[d]) / 32'd4) % 32'd16);
        eerr = model_err(d, a);
        erd  = 32'h0;
        if (!eerr) begin
            if (wen) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                erd = mdl[d][idx];
            end
        end
    endfunction

    // Full transaction with protocol timing checks; hold = cycles of resp backpressure
    task automatic xact(input int d, input logic wen, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input int hold,
                        output logic [31:0] rd, output logic er, output time t_acc);
        int cyc;
        cyc = 0;
        while (rq_ready_o[d] !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        if (rq_ready_o[d] !== 1'b1) begin
            tests++; fails++;
            $display("FAIL req_ready_timeout dut%0d: req_ready=%b required 1", d, rq_ready_o[d]);
        end
        rq_valid[d] = 1'b1; rq_wen[d] = wen; rq_addr[d] = a; rq_wdata[d] = wd; rq_wstrb[d] = s;
        rs_ready[d] = 1'b0;
        @(posedge clk); t_acc = $time; #1;
        // Keep valid high with junk fields: must be ignored outside IDLE
        rq_wen[d] = 1'($urandom); rq_addr[d] = $urandom; rq_wdata[d] = $urandom; rq_wstrb[d] = 4'($urandom);
        cyc = 0;
        while (rs_valid_o[d] !== 1'b1 && cyc < 40) begin
            tests++;
            if (rq_ready_o[d] !== 1'b0) begin
                fails++;
                $display("FAIL busy_req_ready dut%0d: req_ready=%b required 0", d, rq_ready_o[d]);
            end
            @(posedge clk); #1; cyc++;
        end
        tests++;
        if (cyc != wait_c[d] + 1) begin
            fails++;
            $display("FAIL latency dut%0d: resp_valid after %0d edges, required %0d", d, cyc, wait_c[d] + 1);
        end
        rd = rs_rdata_o[d];
        er = rs_err_o[d];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            tests++;
            if (rs_valid_o[d] !== 1'b1 || rs_rdata_o[d] !== rd || rs_err_o[d] !== er || rq_ready_o[d] !== 1'b0) begin
                fails++;
                $display("FAIL hold dut%0d: valid=%b rdata=%h err=%b req_ready=%b required 1/%h/%b/0",
                         d, rs_valid_o[d], rs_rdata_o[d], rs_err_o[d], rq_ready_o[d], rd, er);
            end
        end
        rs_ready[d] = 1'b1;
        @(posedge clk); #1;
        rs_ready[d] = 1'b0;
        rq_valid[d] = 1'b0;
        tests++;
        if (rs_valid_o[d] !== 1'b0 || rq_ready_o[d] !== 1'b1) begin
            fails++;
            $display("FAIL release dut%0d: resp_valid=%b req_ready=%b required 0/1", d, rs_valid_o[d], rq_ready_o[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rq_valid[d] = 0; rq_wen[d] = 0; rq_addr[d] = 0; rq_wdata[d] = 0; rq_wstrb[d] = 0; rs_ready[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (rq_ready_o[d] !== 1'b1 || rs_valid_o[d] !== 1'b0 || rs_rdata_o[d] !== 32'h0 || rs_err_o[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset dut%0d: req_ready=%b resp_valid=%b rdata=%h err=%b required 1/0/0/0",
                         d, rq_ready_o[d], rs_valid_o[d], rs_rdata_o[d], rs_err_o[d]);
            end
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_init();
        logic [31:0] rd, erd; logic er, eer; time t;
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++) begin
                logic [31:0] a, v;
                a = base[d] + 32'(4 * w);
                v = $urandom;
                model_apply(d, 1'b1, a, v, 4'hF, erd, eer);
                xact(d, 1'b1, a, v, 4'hF, 0, rd, er, t);
                tests++;
                if (rd !== erd || er !== eer) begin
                    fails++;
                    $display("FAIL init_store dut%0d w%0d: rdata=%h err=%b required %h/%b", d, w, rd, er, erd, eer);
                end
            end
    endtask

    task automatic test_basic();
        logic [31:0] rd, erd; logic er, eer; time t;
        model_apply(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, t);
        tests++;
        if (rd !== 32'h0) begin
            fails++; $display("FAIL basic_store_rdata: rdata=%h required 00000000", rd);
        end
        model_apply(0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, t);
        tests++;
        if (rd !== 32'hDEADBEEF || rd !== erd) begin
            fails++; $display("FAIL basic_load: rdata=%h required deadbeef", rd);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] rd, erd; logic er, eer; time t;
        model_apply(0, 1'b1, 32'h20, 32'h11223344, 4'hF, erd, eer);
        xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, t);
        model_apply(0, 1'b1, 32'h20, 32'h000000AA, 4'b0001, erd, eer);
        xact(0, 1'b1, 32'h20, 32'h000000AA, 4'b0001, 0, rd, er, t);
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, t);
        tests++;
        if (rd !== 32'h112233AA) begin
            fails++; $display("FAIL strobe_lane0: rdata=%h required 112233aa", rd);
        end
        xact(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd, er, t);
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, t);
        tests++;
        if (rd !== 32'h112233AA) begin
            fails++; $display("FAIL strobe_none: rdata=%h required 112233aa", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, erd; logic er, eer; time t;
        model_apply(0, 1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 5, rd, er, t);
        tests++;
        if (rd !== erd) begin
            fails++; $display("FAIL backpressure_data: rdata=%h required %h", rd, erd);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, erd; logic er, eer; time t;
        model_apply(0, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, erd, eer);
        xact(0, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, 0, rd, er, t);
        model_apply(0, 1'b0, 32'h00, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h00, 32'h0, 4'h0, 0, rd, er, t);
        tests++;
        if (rd !== erd || er !== eer) begin
            fails++; $display("FAIL wrap: rdata=%h err=%b required %h/%b", rd, er, erd, eer);
        end
`ifndef MEM_RESP_ERR_EN
        tests++;
        if (rd !== 32'h5A5A5A5A) begin
            fails++; $display("FAIL wrap_const: rdata=%h required 5a5a5a5a", rd);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; time t1, t2;
        for (int d = 0; d < 2; d++) begin
            xact(d, 1'b0, base[d], 32'h0, 4'h0, 0, rd, er, t1);
            xact(d, 1'b0, base[d] + 32'h4, 32'h0, 4'h0, 0, rd, er, t2);
            tests++;
            if ((t2 - t1) / 10 != wait_c[d] + 3) begin
                fails++;
                $display("FAIL back_to_back dut%0d: %0d cycles per transaction required %0d", d, (t2 - t1) / 10, wait_c[d] + 3);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd, erd; logic er, eer; time t;
        model_apply(1, 1'b1, 32'h108, 32'h13572468, 4'hF, erd, eer);
        xact(1, 1'b1, 32'h108, 32'h13572468, 4'hF, 0, rd, er, t);
        rq_valid[1] = 1'b1; rq_wen[1] = 1'b1; rq_addr[1] = 32'h108; rq_wdata[1] = 32'hCAFEF00D; rq_wstrb[1] = 4'hF;
        @(posedge clk); #1;
        rq_valid[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++;
        if (rq_ready_o[1] !== 1'b1 || rs_valid_o[1] !== 1'b0 || rs_rdata_o[1] !== 32'h0 || rs_err_o[1] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_wait: req_ready=%b resp_valid=%b rdata=%h err=%b required 1/0/0/0",
                     rq_ready_o[1], rs_valid_o[1], rs_rdata_o[1], rs_err_o[1]);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        xact(1, 1'b0, 32'h108, 32'h0, 4'h0, 0, rd, er, t);
        tests++;
        if (rd !== 32'h13572468) begin
            fails++; $display("FAIL reset_discard: rdata=%h required 13572468", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd; logic er, eer, wen; logic [3:0] s; time t; int d;
        for (int n = 0; n < 80; n++) begin
            d   = int'($urandom_range(0, 1));
            wen = 1'($urandom);
            a   = base[d] + 32'($urandom_range(0, 32'h7F));
            wd  = $urandom;
            s   = 4'($urandom);
            model_apply(d, wen, a, wd, s, erd, eer);
            xact(d, wen, a, wd, s, int'($urandom_range(0, 3)), rd, er, t);
            tests++;
            if (rd !== erd || er !== eer) begin
                fails++;
                $display("FAIL random#%0d dut%0d wen=%b addr=%h: rdata=%h err=%b required %h/%b",
                         n, d, wen, a, rd, er, erd, eer);
            end
        end
    endtask

`ifdef MEM_RESP_ERR_EN
    task automatic test_err();
        logic [31:0] rd, erd; logic er, eer; time t;
        xact(0, 1'b0, 32'h6, 32'h0, 4'h0, 0, rd, er, t);
        tests++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            fails++; $display("FAIL err_misaligned: err=%b rdata=%h required 1/00000000", er, rd);
        end
        xact(0, 1'b0, 32'd64, 32'h0, 4'h0, 0, rd, er, t);
        tests++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            fails++; $display("FAIL err_range: err=%b rdata=%h required 1/00000000", er, rd);
        end
        xact(0, 1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, 0, rd, er, t);
        model_apply(0, 1'b0, 32'h4, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er, t);
        tests++;
        if (er !== 1'b0 || rd !== erd) begin
            fails++; $display("FAIL err_no_write: err=%b rdata=%h required 0/%h", er, rd, erd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_init();
        test_basic();
        test_strobe();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef MEM_RESP_ERR_EN
        test_err();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's fetch/load/store requests: accepts one request at a time over a valid/ready handshake, inserts configurable wait states, performs the word access, and holds the response until the core accepts it.
- Sits between the core's fetch/memory stages and the on-chip word storage.
- Replaces the core's ad-hoc delayed load pulse with a defined, cycle-exact protocol.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- WAIT_CYCLES, 1, extra cycles between request acceptance and access; range 0..15.
- BASE_ADDR, 32'h0, byte address mapped to word index 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_wen  input  1  1 = store, 0 = load/fetch.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte enables for stores; bit i enables byte lane [8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  core accepts response.
- resp_rdata  output  32  load data; 0 for stores.
- resp_err  output  1  access error; present only with MEM_RESP_ERR_EN.

Behaviour:
- Reset values: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
- Storage contents are not reset.
- Asserting rst mid-transaction returns the block to IDLE immediately. A store still in WAIT is discarded; a store already committed stays.
- States:
  - IDLE: req_ready = 1. On req_valid & req_ready, capture addr, wdata, wstrb and wen. Go to WAIT with counter = WAIT_CYCLES if WAIT_CYCLES > 0, else go directly to ACCESS.
  - WAIT: req_ready = 0; counter decrements each cycle; at counter == 1, go to ACCESS.
  - ACCESS: one cycle.
    - Store: write enabled byte lanes at the edge leaving ACCESS.
    - Load: register the word into resp_rdata at the same edge.
    - Then go to RESP.
  - RESP: resp_valid = 1; resp_rdata and resp_err are stable until resp_valid & resp_ready; then go to IDLE.
- Latency: request accepted at edge N → resp_valid high after edge N + WAIT_CYCLES + 1.
- Minimum cycles per transaction: WAIT_CYCLES + 3 (next acceptance is in IDLE, the cycle after the response handshake).
- req_ready is 0 in every state except IDLE. Request inputs are ignored outside IDLE.
- A response handshake and a new request never complete in the same cycle.
- Word index = ((addr - BASE_ADDR) >> 2) & (DEPTH_WORDS - 1); the index wraps modulo depth.
- Store with wstrb = 4'b0000: no bytes change; a response is still produced.
- Load-after-store to the same word returns the new data (store is committed before any later ACCESS).
- Without the optional feature, addr[1:0] is ignored.

Optional Feature:
- Macro: MEM_RESP_ERR_EN.
- Defined:
  - resp_err port exists.
  - An error is flagged when addr[1:0] != 0 or (addr - BASE_ADDR) >= 4*DEPTH_WORDS.
  - On error: no write, resp_rdata = 0, resp_err = 1 for that response.
  - Index wrap applies only to non-error accesses.
- Undefined:
  - Port absent; no checking; wrap and ignore-low-bits rules apply.
- Protocol timing is identical in both builds.

Decomposition:
- Package mem_pkg:
  - state encoding IDLE/WAIT/ACCESS/RESP (2 bits).
  - XLEN = 32, STRB_W = 4, MEM_LOAD/MEM_WRITE command constants.
- Sub-module mem_array:
  - storage for DEPTH_WORDS x 32 bits.
  - synchronous byte-enabled write.
  - registered read at ACCESS.
  - no reset.
- mem_responder keeps only the FSM, capture registers and counter.

Test Plan:
- WAIT_CYCLES = 1: store addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF; then load 0x10 → resp_rdata = 0xDEADBEEF; resp_valid rises exactly 2 edges after each acceptance.
- Byte strobe: preload 0x11223344 at 0x20, store 0x000000AA with wstrb 4'b0001, load 0x20 → 0x112233AA.
- Backpressure: hold resp_ready = 0 for 5 cycles on a load → resp_valid and resp_rdata stay constant and req_ready = 0 throughout; release → IDLE next cycle.
- Wrap (DEPTH_WORDS = 16, feature off): store 0x5A5A5A5A to 0x40, load 0x00 → 0x5A5A5A5A.
- Reset mid-WAIT (WAIT_CYCLES = 4): assert rst 2 cycles after accepting a store of 0xCAFEF00D to 0x8 → outputs return to reset values asynchronously; a later load of 0x8 returns the prior contents.
- MEM_RESP_ERR_EN: load 0x6 and load 4*DEPTH_WORDS → resp_err = 1, resp_rdata = 0; store to 0x6 leaves memory unchanged.
